// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants used by the hazard controller and pipeline registers.
package riscv_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// taken-branch squash, data-memory freeze with watchdog, and performance counters.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegRd,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegRs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegRs2,
    input  logic                  IF_ID_UsesRs1,
    input  logic                  IF_ID_UsesRs2,
    input  logic                  EX_BranchTaken,
    input  logic                  DMem_Req,
    input  logic                  DMem_Ready,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  Freeze,
    output logic                  MemTimeout,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    hz_state_t   r_state;
    logic [2:0]  r_lu_cnt;
    logic [15:0] r_wd_cnt;
    logic        r_mem_timeout;

    logic w_freeze;
    logic w_lu_hit;
    logic w_branch;
    logic w_lu_stall;
    logic w_wd_expire;

    assign w_freeze = DMem_Req & ~DMem_Ready;

    assign w_lu_hit = (r_state == RUN) & ID_EX_MemRead & (ID_EX_RegRd != '0) &
                      (((ID_EX_RegRd == IF_ID_RegRs1) & IF_ID_UsesRs1) |
                       ((ID_EX_RegRd == IF_ID_RegRs2) & IF_ID_UsesRs2));

    // Strict priority: freeze masks everything, a branch cancels any pending load-use stall.
    assign w_branch   = ~w_freeze & EX_BranchTaken;
    assign w_lu_stall = ~w_freeze & ~EX_BranchTaken & (w_lu_hit | (r_state == LU_STALL));

    assign w_wd_expire = ({1'b0, r_wd_cnt} + 17'd1) == 17'(MEM_TIMEOUT);

    // NOTE: every variable gets a default before the priority chain so no latch is inferred.
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Freeze      = 1'b0;
        if (w_freeze) begin
            Freeze      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (w_branch) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_lu_stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_lu_cnt      <= '0;
            r_wd_cnt      <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_freeze) begin
                if (r_wd_cnt != 16'hFFFF) begin
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                end
                if (w_wd_expire) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end

            if (w_branch) begin
                r_state  <= RUN;
                r_lu_cnt <= '0;
            end else if (w_lu_stall) begin
                if (r_state == RUN) begin
                    // A single-bubble configuration never needs the counting state.
                    if (LOAD_USE_STALLS > 1) begin
                        r_state  <= LU_STALL;
                        r_lu_cnt <= 3'(LOAD_USE_STALLS - 1);
                    end
                end else begin
                    r_lu_cnt <= r_lu_cnt - 3'd1;
                    if (r_lu_cnt == 3'd1) begin
                        r_state <= RUN;
                    end
                end
            end
        end
    end

    assign MemTimeout = r_mem_timeout;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_freeze | w_lu_stall),
        .count (StallCount)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_branch),
        .count (FlushCount)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequences the stall, bubble, flush and freeze controls of the 5-stage RV32I pipeline. It sits beside the forwarding logic, which handles ALU-to-ALU hazards and cannot resolve the following cases:
- load-use hazards (configurable bubble count),
- taken branches/jumps resolved in EX (2-instruction squash),
- data-memory wait states (whole-pipeline freeze with a timeout watchdog).

It also keeps stall and flush performance counters.

## Interface
Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7)
- MEM_TIMEOUT, 255, consecutive freeze cycles that raise MemTimeout (1..2^16-1)
- CNT_W, 32, performance counter width

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegRd  in  5  destination of instruction in EX
- IF_ID_RegRs1 / IF_ID_RegRs2  in  5 each  sources of instruction in ID
- IF_ID_UsesRs1 / IF_ID_UsesRs2  in  1 each  source actually read
- EX_BranchTaken  in  1  EX redirects PC this cycle
- DMem_Req  in  1  MEM stage holds a load/store
- DMem_Ready  in  1  data memory completes access this cycle
- PCWrite  out  1  PC may update
- IF_ID_Write  out  1  IF/ID may load
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Flush  out  1  ID/EX loads a bubble
- Freeze  out  1  hold ID/EX and EX/MEM; MEM/WB loads a bubble
- MemTimeout  out  1  sticky watchdog error
- StallCount  out  CNT_W  cycles with Freeze or a load-use stall
- FlushCount  out  CNT_W  taken-branch flush events

## Operation
- States: RUN, LU_STALL.
- Registers: state, lu_cnt [2:0], wd_cnt [15:0], MemTimeout, StallCount, FlushCount.
- freeze = DMem_Req & !DMem_Ready.
- lu_hit (RUN only) = ID_EX_MemRead & ID_EX_RegRd!=0 & ((ID_EX_RegRd==IF_ID_RegRs1 & IF_ID_UsesRs1) | (ID_EX_RegRd==IF_ID_RegRs2 & IF_ID_UsesRs2)).
- Priority is freeze > branch > load-use. Exactly one action applies per cycle.
- Freeze:
  - Outputs: Freeze=1, PCWrite=0, IF_ID_Write=0, both flushes 0.
  - State and lu_cnt hold.
  - A branch asserted during freeze is serviced on the first unfrozen cycle; EX holds, so EX_BranchTaken persists.
- Branch (no freeze):
  - Outputs: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1.
  - state←RUN and lu_cnt←0, cancelling any stall in progress.
  - FlushCount+1.
- Load-use stall, entered on lu_hit in RUN or while in LU_STALL (no freeze, no branch):
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
  - In RUN with lu_hit: if LOAD_USE_STALLS>1, state←LU_STALL and lu_cnt←LOAD_USE_STALLS-1; otherwise stay in RUN.
  - In LU_STALL: lu_cnt decrements; when lu_cnt==1 at the edge, state←RUN.
- Idle: PCWrite=1, IF_ID_Write=1, all other control outputs 0.
- Watchdog:
  - wd_cnt increments on each freeze cycle and clears when freeze is 0. It saturates.
  - MemTimeout←1 when wd_cnt+1==MEM_TIMEOUT. It stays 1 until rst.
  - MemTimeout does not affect pipeline controls.
- Counters:
  - StallCount increments on every freeze or load-use stall cycle.
  - FlushCount increments per branch action.
  - Both wrap modulo 2^CNT_W.

## Timing
- PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush and Freeze are combinational from state and inputs, with zero latency.
- State, counters and MemTimeout update on the rising edge of clk.
- On rst (overrides everything at the edge):
  - state=RUN, lu_cnt=0, wd_cnt=0, MemTimeout=0, StallCount=0, FlushCount=0.
  - With idle inputs, outputs are PCWrite=1, IF_ID_Write=1, others 0.
- Reset mid-stall or mid-freeze abandons the sequence. The next cycle behaves as RUN.
- Each load-use hazard costs exactly LOAD_USE_STALLS bubble cycles, plus any interleaved freeze cycles.
- A taken branch costs 2 squashed instructions. The flush lasts 1 cycle.
- A rs match on x0 never stalls.

## Structure
- Package `riscv_pkg` holds:
  - `hz_state_t` (RUN, LU_STALL)
  - `REG_ADDR_W`=5
  - `NOP_INSTR`=32'h0000_0013, used by the pipeline registers on flush
- Sub-module `perf_counter` (CNT_W, inc, rst, clk → count) is instantiated twice, for StallCount and FlushCount.
- Everything else is inline in `pipeline_hazard_ctrl`.

## Test plan
- Load-use, LOAD_USE_STALLS=1:
  - Stimulus: ID_EX_MemRead=1, RegRd=5, Rs1=5, UsesRs1=1.
  - Response: one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount=1.
  - Repeat with RegRd=0 → no stall.
- LOAD_USE_STALLS=3:
  - Stimulus: a single-cycle lu_hit.
  - Response: 3 consecutive bubble cycles, then RUN.
  - Variant: EX_BranchTaken on the 2nd bubble → flush outputs, stall aborted, FlushCount=1.
- Freeze precedence:
  - Stimulus: DMem_Req=1 with DMem_Ready=0 for 4 cycles, with EX_BranchTaken=1 throughout.
  - Response: Freeze=1 and no flush for 4 cycles; flush on cycle 5; StallCount=4.
- Watchdog, MEM_TIMEOUT=8:
  - 7 freeze cycles → MemTimeout=0.
  - 8th freeze cycle → MemTimeout=1 after the edge; it stays 1 after freeze ends and clears only on rst.
- Reset mid-LU_STALL:
  - Stimulus: rst during LU_STALL with counters nonzero.
  - Response: all registers 0 and state RUN at the next cycle; idle outputs PCWrite=1, IF_ID_Write=1.
- Counter wrap:
  - Stimulus: CNT_W=4 with 17 branch flushes.
  - Response: FlushCount=1.
